// File: rtl/sreg_flag_unit_pkg.sv
// Shared definitions for the AVR status register unit: SREG bit positions,
// flag update encoding and the default reset image.
package sreg_flag_unit_pkg;

  localparam int SREG_I = 7;
  localparam int SREG_T = 6;
  localparam int SREG_H = 5;
  localparam int SREG_S = 4;
  localparam int SREG_V = 3;
  localparam int SREG_N = 2;
  localparam int SREG_Z = 1;
  localparam int SREG_C = 0;

  typedef enum logic [1:0] {
    FLAG_NONE   = 2'b00,
    FLAG_ARITH  = 2'b01,
    FLAG_LOGIC  = 2'b10,
    FLAG_INCDEC = 2'b11
  } flag_op_e;

  localparam logic [7:0] SREG_RESET_DEFAULT = 8'h00;

  // Bits each flag_op class is allowed to overwrite; I and T are never included.
  function automatic logic [7:0] flag_write_mask(input flag_op_e op);
    logic [7:0] mask;
    mask = 8'h00;
    case (op)
      FLAG_ARITH:  mask = 8'h3F;
      FLAG_LOGIC:  mask = 8'h1E;
      FLAG_INCDEC: mask = 8'h1E;
      default:     mask = 8'h00;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/sreg_flag_calc.sv
// Combinational AVR flag computation from the adder's operands, result and
// carry/borrow out.
module sreg_flag_calc (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [7:0] S,
  input  logic       Cout,
  input  logic       Add_n_Sub,
  input  logic       z_old,
  input  logic       chain,
  output logic       flag_h,
  output logic       flag_s,
  output logic       flag_v,
  output logic       flag_n,
  output logic       flag_z,
  output logic       flag_c
);

  always_comb begin
    flag_h = 1'b0;
    flag_v = 1'b0;
    if (Add_n_Sub) begin
      flag_h = (~A[3] & B[3]) | (B[3] & S[3]) | (S[3] & ~A[3]);
      flag_v = (A[7] & ~B[7] & ~S[7]) | (~A[7] & B[7] & S[7]);
    end else begin
      flag_h = (A[3] & B[3]) | (B[3] & ~S[3]) | (~S[3] & A[3]);
      flag_v = (A[7] & B[7] & ~S[7]) | (~A[7] & ~B[7] & S[7]);
    end
    // The adder reports "no borrow" on subtract; AVR C is the borrow itself.
    flag_c = Add_n_Sub ? ~Cout : Cout;
    flag_n = S[7];
    flag_s = flag_n ^ flag_v;
    flag_z = (S == 8'h00) & (chain ? z_old : 1'b1);
  end

endmodule

// File: rtl/sreg_flag_unit.sv
// AVR SREG: flag updates from the ALU plus BSET/BCLR, I/O writes, interrupt
// entry and RETI. Define SREG_CFWD_EN to forward next-state C on c_fwd.
module sreg_flag_unit
  import sreg_flag_unit_pkg::*;
#(
  parameter logic [7:0] RESET_VALUE = SREG_RESET_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [7:0] S,
  input  logic       Cout,
  input  logic       Add_n_Sub,
  input  logic       flag_en,
  input  logic [1:0] flag_op,
  input  logic       chain,
  input  logic       bit_set,
  input  logic       bit_clr,
  input  logic [2:0] bit_idx,
  input  logic       io_we,
  input  logic [7:0] io_wdata,
  input  logic       int_ack,
  input  logic       reti,
  output logic [7:0] sreg,
  output logic       c_fwd
);

  logic [7:0] sreg_p1;
  logic [7:0] sreg_nxt;
  logic [7:0] flag_vec;
  logic [7:0] flag_mask;
  flag_op_e   op;
  logic       chain_eff;
  logic       calc_h, calc_s, calc_v, calc_n, calc_z, calc_c;

  assign op = flag_op_e'(flag_op);
  // Sticky Z only makes sense for the multi-byte arithmetic forms.
  assign chain_eff = chain & (op == FLAG_ARITH);

  sreg_flag_calc u_calc (
    .A         (A),
    .B         (B),
    .S         (S),
    .Cout      (Cout),
    .Add_n_Sub (Add_n_Sub),
    .z_old     (sreg_p1[SREG_Z]),
    .chain     (chain_eff),
    .flag_h    (calc_h),
    .flag_s    (calc_s),
    .flag_v    (calc_v),
    .flag_n    (calc_n),
    .flag_z    (calc_z),
    .flag_c    (calc_c)
  );

  always_comb begin
    flag_vec  = {2'b00, calc_h, calc_s, calc_v & (op != FLAG_LOGIC), calc_n, calc_z, calc_c};
    flag_vec[SREG_S] = calc_n ^ (calc_v & (op != FLAG_LOGIC));
    flag_mask = flag_write_mask(op);
  end

  // Stage p0 -> p1: single-winner event priority.
  always_comb begin
    sreg_nxt = sreg_p1;
    if (io_we) begin
      sreg_nxt = io_wdata;
    end else if (int_ack) begin
      sreg_nxt[SREG_I] = 1'b0;
    end else if (reti) begin
      sreg_nxt[SREG_I] = 1'b1;
    end else if (bit_clr) begin
      sreg_nxt[bit_idx] = 1'b0;
    end else if (bit_set) begin
      sreg_nxt[bit_idx] = 1'b1;
    end else if (flag_en) begin
      sreg_nxt = (sreg_p1 & ~flag_mask) | (flag_vec & flag_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_p1 <= RESET_VALUE;
    end else begin
      sreg_p1 <= sreg_nxt;
    end
  end

  assign sreg = sreg_p1;

`ifdef SREG_CFWD_EN
  assign c_fwd = rst ? RESET_VALUE[SREG_C] : sreg_nxt[SREG_C];
`else
  assign c_fwd = sreg_p1[SREG_C];
`endif

endmodule

// File: tb/tb_sreg_flag_unit.sv
// Self-checking bench for sreg_flag_unit: hand-computed vector table,
// corner-case sequences and a randomized run against a reference model.
module tb_sreg_flag_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] A, B, S;
  logic       Cout, Add_n_Sub, flag_en, chain, bit_set, bit_clr;
  logic [1:0] flag_op;
  logic [2:0] bit_idx;
  logic       io_we, int_ack, reti;
  logic [7:0] io_wdata;
  logic [7:0] sreg;
  logic       c_fwd;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rst;
    logic [7:0] a, b, s;
    logic       cout, sub, flag_en;
    logic [1:0] flag_op;
    logic       chain, bset, bclr;
    logic [2:0] idx;
    logic       io_we;
    logic [7:0] wdata;
    logic       int_ack, reti;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] sb[$];

  sreg_flag_unit #(.RESET_VALUE(8'h00)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .S(S), .Cout(Cout), .Add_n_Sub(Add_n_Sub),
    .flag_en(flag_en), .flag_op(flag_op), .chain(chain), .bit_set(bit_set),
    .bit_clr(bit_clr), .bit_idx(bit_idx), .io_we(io_we), .io_wdata(io_wdata),
    .int_ack(int_ack), .reti(reti), .sreg(sreg), .c_fwd(c_fwd)
  );

  always #5 clk = ~clk;

  function automatic vec_t blank(input string n, input logic [7:0] e);
    vec_t v;
    v.rst = 0; v.a = 0; v.b = 0; v.s = 0; v.cout = 0; v.sub = 0; v.flag_en = 0;
    v.flag_op = 0; v.chain = 0; v.bset = 0; v.bclr = 0; v.idx = 0; v.io_we = 0;
    v.wdata = 0; v.int_ack = 0; v.reti = 0; v.exp = e; v.name = n;
    return v;
  endfunction

  function automatic vec_t alu(input string n, input logic [7:0] a, b, s, input logic cout,
                               input logic sub, input logic [1:0] op, input logic ch,
                               input logic [7:0] e);
    vec_t v;
    v = blank(n, e);
    v.a = a; v.b = b; v.s = s; v.cout = cout; v.sub = sub;
    v.flag_en = 1; v.flag_op = op; v.chain = ch;
    return v;
  endfunction

  function automatic vec_t io(input string n, input logic [7:0] d);
    vec_t v;
    v = blank(n, d);
    v.io_we = 1; v.wdata = d;
    return v;
  endfunction

  function automatic vec_t bitop(input string n, input logic st, input logic cl,
                                 input logic [2:0] idx, input logic [7:0] e);
    vec_t v;
    v = blank(n, e);
    v.bset = st; v.bclr = cl; v.idx = idx;
    return v;
  endfunction

  // Independent reference: flags from arithmetic definitions, not the bit equations.
  function automatic logic [7:0] model_next(input logic [7:0] cur, input vec_t v, input logic cin);
    logic [7:0] nx;
    logic h, vv, n, z, c;
    nx = cur;
    if (v.rst) return 8'h00;
    if (v.io_we) return v.wdata;
    if (v.int_ack) begin nx[7] = 0; return nx; end
    if (v.reti) begin nx[7] = 1; return nx; end
    if (v.bclr) begin nx[v.idx] = 0; return nx; end
    if (v.bset) begin nx[v.idx] = 1; return nx; end
    if (!v.flag_en || v.flag_op == 2'b00) return nx;
    if (v.sub) begin
      h  = ({1'b0, v.a[3:0]} < ({1'b0, v.b[3:0]} + {4'd0, cin}));
      vv = (v.a[7] != v.b[7]) && (v.s[7] != v.a[7]);
      c  = !v.cout;
    end else begin
      h  = ({1'b0, v.a[3:0]} + {1'b0, v.b[3:0]} + {4'd0, cin}) > 5'h0F;
      vv = (v.a[7] == v.b[7]) && (v.s[7] != v.a[7]);
      c  = v.cout;
    end
    n = v.s[7];
    z = (v.s == 8'h00) && ((v.chain && v.flag_op == 2'b01) ? cur[1] : 1'b1);
    if (v.flag_op == 2'b10) vv = 0;
    nx[4] = n ^ vv; nx[3] = vv; nx[2] = n; nx[1] = z;
    if (v.flag_op == 2'b01) begin nx[5] = h; nx[0] = c; end
    return nx;
  endfunction

  task automatic check(input string n, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", n, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    logic [7:0] e;
    @(negedge clk);
    rst = v.rst; A = v.a; B = v.b; S = v.s; Cout = v.cout; Add_n_Sub = v.sub;
    flag_en = v.flag_en; flag_op = v.flag_op; chain = v.chain; bit_set = v.bset;
    bit_clr = v.bclr; bit_idx = v.idx; io_we = v.io_we; io_wdata = v.wdata;
    int_ack = v.int_ack; reti = v.reti;
    sb.push_back(v.exp);
    #1;
`ifdef SREG_CFWD_EN
    check({v.name, " c_fwd"}, {7'd0, c_fwd}, {7'd0, v.exp[0]});
`endif
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(v.name, sreg, e);
`ifndef SREG_CFWD_EN
    check({v.name, " c_fwd"}, {7'd0, c_fwd}, {7'd0, e[0]});
`endif
  endtask

  initial begin
    vec_t       v;
    logic [7:0] cur;
    logic [8:0] t;
    logic       cin;

    rst = 1; A = 0; B = 0; S = 0; Cout = 0; Add_n_Sub = 0; flag_en = 0; flag_op = 0;
    chain = 0; bit_set = 0; bit_clr = 0; bit_idx = 0; io_we = 0; io_wdata = 0;
    int_ack = 0; reti = 0;

    v = blank("reset", 8'h00); v.rst = 1; tbl.push_back(v);
    tbl.push_back(alu("add_7f_01",   8'h7F, 8'h01, 8'h80, 0, 0, 2'b01, 0, 8'h2C));
    tbl.push_back(alu("sub_00_01",   8'h00, 8'h01, 8'hFF, 0, 1, 2'b01, 0, 8'h35));
    tbl.push_back(io("io_z1", 8'h02));
    tbl.push_back(alu("chain_b1",    8'h05, 8'h05, 8'h00, 1, 1, 2'b01, 1, 8'h02));
    tbl.push_back(alu("chain_b2",    8'h05, 8'h04, 8'h01, 1, 1, 2'b01, 1, 8'h00));
    tbl.push_back(alu("chain_b3",    8'h05, 8'h05, 8'h00, 1, 1, 2'b01, 1, 8'h00));
    v = alu("multi_event", 8'h7F, 8'h01, 8'h80, 0, 0, 2'b01, 0, 8'hA5);
    v.io_we = 1; v.wdata = 8'hA5; v.int_ack = 1; v.bset = 1; v.idx = 0;
    tbl.push_back(v);
    v = blank("int_ack", 8'h25); v.int_ack = 1; tbl.push_back(v);
    tbl.push_back(io("io_40", 8'h40));
    tbl.push_back(bitop("set_clr_6", 1, 1, 3'd6, 8'h00));
    v = blank("reti", 8'h80); v.reti = 1; tbl.push_back(v);
    tbl.push_back(bitop("bset_5", 1, 0, 3'd5, 8'hA0));
    tbl.push_back(bitop("bset_0", 1, 0, 3'd0, 8'hA1));
    tbl.push_back(alu("logic_neg",   8'hF0, 8'h80, 8'h80, 0, 0, 2'b10, 0, 8'hB5));
    tbl.push_back(alu("logic_zero",  8'hF0, 8'h0F, 8'h00, 0, 0, 2'b10, 0, 8'hA3));
    tbl.push_back(alu("inc_7f",      8'h7F, 8'h01, 8'h80, 0, 0, 2'b11, 0, 8'hAD));
    tbl.push_back(alu("logic_chain", 8'h00, 8'h00, 8'h00, 0, 0, 2'b10, 1, 8'hA3));
    tbl.push_back(alu("op_none",     8'h7F, 8'h01, 8'h80, 0, 0, 2'b00, 0, 8'hA3));
    v = alu("en_low", 8'h7F, 8'h01, 8'h80, 0, 0, 2'b01, 0, 8'hA3); v.flag_en = 0;
    tbl.push_back(v);
    tbl.push_back(bitop("bclr_7", 0, 1, 3'd7, 8'h23));
    tbl.push_back(bitop("bclr_0", 0, 1, 3'd0, 8'h22));
    tbl.push_back(alu("add_cout",    8'hFF, 8'h01, 8'h00, 1, 0, 2'b01, 0, 8'h23));
    v = blank("rst_after_carry", 8'h00); v.rst = 1; tbl.push_back(v);
    v = io("rst_over_io", 8'hFF); v.rst = 1; v.exp = 8'h00; tbl.push_back(v);

    foreach (tbl[i]) apply(tbl[i]);

    cur = 8'h00;
    for (int k = 0; k < 300; k++) begin
      v = blank($sformatf("rand_%0d", k), 8'h00);
      v.a = 8'($urandom); v.b = 8'($urandom); v.sub = 1'($urandom);
      cin = 1'($urandom);
      if (v.sub) begin
        t = {1'b0, v.a} - {1'b0, v.b} - {8'd0, cin};
        v.s = t[7:0]; v.cout = ~t[8];
      end else begin
        t = {1'b0, v.a} + {1'b0, v.b} + {8'd0, cin};
        v.s = t[7:0]; v.cout = t[8];
      end
      if ($urandom_range(0, 3) == 0) v.s = 8'h00;
      v.rst     = ($urandom_range(0, 39) == 0);
      v.io_we   = ($urandom_range(0, 9) == 0);
      v.wdata   = 8'($urandom);
      v.int_ack = ($urandom_range(0, 9) == 0);
      v.reti    = ($urandom_range(0, 9) == 0);
      v.bset    = ($urandom_range(0, 7) == 0);
      v.bclr    = ($urandom_range(0, 7) == 0);
      v.idx     = 3'($urandom);
      v.flag_en = ($urandom_range(0, 3) != 0);
      v.flag_op = 2'($urandom);
      v.chain   = 1'($urandom);
      // Forced zero results break the adder relationship; only keep them where flags ignore it.
      if (v.s == 8'h00 && t[7:0] != 8'h00) v.flag_op = 2'b10;
      v.exp = model_next(cur, v, cin);
      apply(v);
      cur = v.exp;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
